// File: rtl/ycr_dst_idle_gen.sv
// ycr_dst_idle_gen: destination-domain idle generator.
// Counts outstanding request/response transactions, watches local busy and
// the synchronised source wake request, and raises a registered dst_idle
// level only after a programmable quiet window. Any activity drops it on the
// next edge. dst_idle comes straight from a flop so the source-side
// synchroniser never sees a combinational glitch.
module ycr_dst_idle_gen #(
  parameter int OCNT_W = 4
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              cfg_enb,
  input  logic [3:0]        cfg_idle_cnt,
  input  logic              src_req,
  input  logic              busy_in,
  input  logic              req_valid,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic              resp_ready,
  output logic              dst_idle,
  output logic [OCNT_W-1:0] ocnt,
  output logic              ocnt_full,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam logic [OCNT_W-1:0] OCNT_MAX = '1;
  localparam logic [OCNT_W-1:0] OCNT_ONE = OCNT_W'(1);
  localparam logic [3:0]        HCNT_ONE = 4'd1;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_IDLE   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic       idle_d;
  logic [1:0] src_req_sync;
  logic       src_req_ss;
  logic       req_fire, resp_fire;
  logic       ocnt_zero;
  logic       activity, quiet;

  assign req_fire   = req_valid & req_ready;
  assign resp_fire  = resp_valid & resp_ready;
  assign ocnt_zero  = (ocnt == '0);
  assign ocnt_full  = (ocnt == OCNT_MAX);
  assign src_req_ss = src_req_sync[1];

  // Activity uses the count before this edge's update, so the last response
  // cycle itself still counts as busy.
  assign activity = req_valid | resp_valid | busy_in | src_req_ss | ~ocnt_zero;
  assign quiet    = ~activity;

  // Two-flop synchroniser for the asynchronous wake request.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) src_req_sync <= 2'b00;
    else          src_req_sync <= {src_req_sync[0], src_req};
  end

  // Outstanding counter; saturates at both ends and latches sticky errors.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      ocnt    <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (req_fire && !resp_fire) begin
      if (ocnt_full) err_ovf <= 1'b1;
      else           ocnt    <= ocnt + OCNT_ONE;
    end else if (resp_fire && !req_fire) begin
      if (ocnt_zero) err_unf <= 1'b1;
      else           ocnt    <= ocnt - OCNT_ONE;
    end
  end

  // State, hold-off counter and the idle flop.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_ACTIVE;
      hcnt_q   <= 4'd0;
      dst_idle <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      dst_idle <= idle_d;
    end
  end

  // Next-state: quiet window loaded on DRAIN entry, activity always wins.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    idle_d  = dst_idle;
    if (!cfg_enb) begin
      state_d = ST_ACTIVE;
      idle_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          idle_d = 1'b0;
          if (quiet) begin
            state_d = ST_DRAIN;
            hcnt_d  = cfg_idle_cnt;
          end
        end
        ST_DRAIN: begin
          idle_d = 1'b0;
          if (activity) begin
            state_d = ST_ACTIVE;
          end else if (hcnt_q == 4'd0) begin
            state_d = ST_IDLE;
            idle_d  = 1'b1;
          end else begin
            hcnt_d = hcnt_q - HCNT_ONE;
          end
        end
        ST_IDLE: begin
          if (activity) begin
            state_d = ST_ACTIVE;
            idle_d  = 1'b0;
          end else begin
            idle_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_ACTIVE;
          idle_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycr_dst_idle_gen.sv
// Bench for ycr_dst_idle_gen: directed per-cycle vectors with hand-computed
// expectations pushed into a queue; a monitor pops one entry per clock edge
// (or per asynchronous reset assertion) and compares against the DUT.
// Instance A uses the default counter width, instance B uses OCNT_W=2.
module tb_ycr_dst_idle_gen;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b1;
  logic       cfg_enb = 1'b1;
  logic [3:0] cfg_idle_cnt = 4'd3;
  logic       src_req = 1'b0, busy_in = 1'b0;
  logic       req_valid = 1'b0, req_ready = 1'b0;
  logic       resp_valid = 1'b0, resp_ready = 1'b0;

  logic       idle_a, full_a, ovf_a, unf_a;
  logic [3:0] ocnt_a;
  logic       idle_b, full_b, ovf_b, unf_b;
  logic [1:0] ocnt_b;

  ycr_dst_idle_gen #(.OCNT_W(4)) u_dut_a (
    .clk_in(clk_in), .reset_n(reset_n), .cfg_enb(cfg_enb), .cfg_idle_cnt(cfg_idle_cnt),
    .src_req(src_req), .busy_in(busy_in), .req_valid(req_valid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .dst_idle(idle_a), .ocnt(ocnt_a),
    .ocnt_full(full_a), .err_ovf(ovf_a), .err_unf(unf_a)
  );

  ycr_dst_idle_gen #(.OCNT_W(2)) u_dut_b (
    .clk_in(clk_in), .reset_n(reset_n), .cfg_enb(cfg_enb), .cfg_idle_cnt(cfg_idle_cnt),
    .src_req(src_req), .busy_in(busy_in), .req_valid(req_valid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .dst_idle(idle_b), .ocnt(ocnt_b),
    .ocnt_full(full_b), .err_ovf(ovf_b), .err_unf(unf_b)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string tag;
    bit    sel;
    int    idle;
    int    oc;
    int    full;
    int    ovf;
    int    unf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // stimulus codes: {req_valid, req_ready, resp_valid, resp_ready, busy_in, src_req}
  localparam logic [5:0] Q  = 6'b000000;
  localparam logic [5:0] RQ = 6'b110000;
  localparam logic [5:0] RV = 6'b100000;
  localparam logic [5:0] RS = 6'b001100;
  localparam logic [5:0] BT = 6'b111100;
  localparam logic [5:0] BZ = 6'b000010;
  localparam logic [5:0] SR = 6'b000001;

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock edge, or per reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in or negedge reset_n);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk(e.tag, "dst_idle",  int'(idle_a), e.idle);
          chk(e.tag, "ocnt",      int'(ocnt_a), e.oc);
          chk(e.tag, "ocnt_full", int'(full_a), e.full);
          chk(e.tag, "err_ovf",   int'(ovf_a),  e.ovf);
          chk(e.tag, "err_unf",   int'(unf_a),  e.unf);
        end else begin
          chk(e.tag, "dst_idle",  int'(idle_b), e.idle);
          chk(e.tag, "ocnt",      int'(ocnt_b), e.oc);
          chk(e.tag, "ocnt_full", int'(full_b), e.full);
          chk(e.tag, "err_ovf",   int'(ovf_b),  e.ovf);
          chk(e.tag, "err_unf",   int'(unf_b),  e.unf);
        end
      end
    end
  end

  // Called at a negedge: drive one cycle, queue the post-edge expectation.
  task automatic step(input string tag, input logic [5:0] s, input int idle, input int oc,
                      input int full = 0, input int ovf = 0, input int unf = 0,
                      input bit sel = 1'b0);
    exp_t e;
    {req_valid, req_ready, resp_valid, resp_ready, busy_in, src_req} = s;
    e.tag = tag; e.sel = sel; e.idle = idle; e.oc = oc;
    e.full = full; e.ovf = ovf; e.unf = unf;
    q.push_back(e);
    @(negedge clk_in);
  endtask

  // Asserts reset between edges and expects reset values immediately.
  task automatic reset_pulse(input string tag, input bit sel);
    exp_t e;
    e.tag = tag; e.sel = sel; e.idle = 0; e.oc = 0;
    e.full = 0; e.ovf = 0; e.unf = 0;
    {req_valid, req_ready, resp_valid, resp_ready, busy_in, src_req} = Q;
    q.push_back(e);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_in);
    reset_pulse("rst_state", 1'b0);

    // quiet window of cfg_idle_cnt+2 = 5 cycles
    for (int i = 0; i < 4; i++) step("t1_quiet", Q, 0, 0);
    step("t1_rise", Q, 1, 0);
    step("t1_hold", Q, 1, 0);

    // outstanding counting, then idle two quiet cycles after ocnt hits 0
    cfg_idle_cnt = 4'd0;
    step("t2_req1", RQ, 0, 1);
    step("t2_req2", RQ, 0, 2);
    step("t2_req3", RQ, 0, 3);
    step("t2_both", BT, 0, 3);
    step("t2_rsp1", RS, 0, 2);
    step("t2_rsp2", RS, 0, 1);
    step("t2_rsp3", RS, 0, 0);
    step("t2_q1",   Q,  0, 0);
    step("t2_rise", Q,  1, 0);
    step("t2_hold", Q,  1, 0);
    step("t2_rvld", RV, 0, 0);
    step("t2_q2",   Q,  0, 0);
    step("t2_rise2", Q, 1, 0);

    // src_req wake: 2 sync cycles + 1, then 4 quiet cycles to re-idle
    cfg_idle_cnt = 4'd2;
    step("t3_src",  SR, 1, 0);
    step("t3_sync", Q,  1, 0);
    step("t3_drop", Q,  0, 0);
    for (int i = 0; i < 3; i++) step("t3_drain", Q, 0, 0);
    step("t3_rise", Q, 1, 0);

    // busy exactly when hcnt==0 in DRAIN: activity wins
    cfg_idle_cnt = 4'd0;
    step("t4_busy",  BZ, 0, 0);
    step("t4_drain", Q,  0, 0);
    step("t4_race",  BZ, 0, 0);
    step("t4_drain2", Q, 0, 0);
    step("t4_rise",  Q,  1, 0);

    // cfg_idle_cnt change mid-DRAIN is not re-sampled
    step("t4b_busy", BZ, 0, 0);
    cfg_idle_cnt = 4'd1;
    step("t4b_enter", Q, 0, 0);
    cfg_idle_cnt = 4'd7;
    step("t4b_hc0", Q, 0, 0);
    step("t4b_rise", Q, 1, 0);

    // cfg_enb drop while IDLE
    cfg_idle_cnt = 4'd0;
    cfg_enb = 1'b0;
    step("t6_dis",  Q, 0, 0);
    step("t6_dis2", Q, 0, 0);
    cfg_enb = 1'b1;
    step("t6_drain", Q, 0, 0);
    step("t6_rise",  Q, 1, 0);

    // underflow on the wide instance
    step("ta_unf",  RS, 0, 0, 0, 0, 1);
    step("ta_hold", Q,  0, 0, 0, 0, 1);

    // narrow instance: overflow, underflow, then reset mid-DRAIN
    reset_pulse("tb_rst", 1'b1);
    step("tb_req1", RQ, 0, 1, 0, 0, 0, 1'b1);
    step("tb_req2", RQ, 0, 2, 0, 0, 0, 1'b1);
    step("tb_req3", RQ, 0, 3, 1, 0, 0, 1'b1);
    step("tb_ovf",  RQ, 0, 3, 1, 1, 0, 1'b1);
    step("tb_both", BT, 0, 3, 1, 1, 0, 1'b1);
    step("tb_rsp1", RS, 0, 2, 0, 1, 0, 1'b1);
    step("tb_rsp2", RS, 0, 1, 0, 1, 0, 1'b1);
    step("tb_rsp3", RS, 0, 0, 0, 1, 0, 1'b1);
    step("tb_unf",  RS, 0, 0, 0, 1, 1, 1'b1);
    step("tb_drain", Q, 0, 0, 0, 1, 1, 1'b1);
    reset_pulse("tb_async_rst", 1'b1);
    step("tb_post1", Q, 0, 0, 0, 0, 0, 1'b1);
    step("tb_post2", Q, 1, 0, 0, 0, 0, 1'b1);

    repeat (2) @(negedge clk_in);
    chk("scoreboard", "pending", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
